// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 Hz VGA timing constants shared by vga_timing_gen.
package vga_timing_pkg;

  typedef logic [9:0] coord_t;

  localparam int unsigned H_VISIBLE = 640;
  localparam int unsigned H_FP      = 16;
  localparam int unsigned H_SYNC    = 96;
  localparam int unsigned H_BP      = 48;
  localparam int unsigned H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

  localparam int unsigned V_VISIBLE = 480;
  localparam int unsigned V_FP      = 10;
  localparam int unsigned V_SYNC    = 2;
  localparam int unsigned V_BP      = 33;
  localparam int unsigned V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam int unsigned H_SYNC_START = H_VISIBLE + H_FP;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
  localparam int unsigned V_SYNC_START = V_VISIBLE + V_FP;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

  // 10-bit copies so all compares stay unsigned and width-matched
  localparam coord_t H_VIS_C      = coord_t'(H_VISIBLE);
  localparam coord_t H_LAST_C     = coord_t'(H_TOTAL - 1);
  localparam coord_t H_SYNC_BEG_C = coord_t'(H_SYNC_START);
  localparam coord_t H_SYNC_END_C = coord_t'(H_SYNC_END);
  localparam coord_t V_VIS_C      = coord_t'(V_VISIBLE);
  localparam coord_t V_LAST_C     = coord_t'(V_TOTAL - 1);
  localparam coord_t V_SYNC_BEG_C = coord_t'(V_SYNC_START);
  localparam coord_t V_SYNC_END_C = coord_t'(V_SYNC_END);

  function automatic logic in_span(input coord_t v, input coord_t lo, input coord_t hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480 VGA counters plus registered coordinate/sync/blank decode.
// Optional macro VGA_TIMING_LOOKAHEAD_EN: DrawX/DrawY present the next pixel,
// one cycle ahead of blank/hs/vs/frame_start.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned FRAME_CNT_W = 8
) (
  input  logic                   vga_clk,
  input  logic                   reset_n,
  output logic [9:0]             DrawX,
  output logic [9:0]             DrawY,
  output logic                   blank,
  output logic                   hs,
  output logic                   vs,
  output logic                   frame_start,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  coord_t r_hc, r_vc;
  coord_t w_hc_next, w_vc_next;
  coord_t w_x_src, w_y_src;
  logic   w_h_wrap, w_v_wrap, w_frame_start;

  coord_t                 r_draw_x, r_draw_y;
  logic                   r_blank, r_hs, r_vs, r_frame_start;
  logic [FRAME_CNT_W-1:0] r_frame_cnt;

  // Next-count logic: hc wraps 799->0, vc advances only on hc wrap
  always_comb begin
    w_h_wrap      = (r_hc == H_LAST_C);
    w_v_wrap      = (r_vc == V_LAST_C);
    w_hc_next     = w_h_wrap ? '0 : r_hc + 10'd1;
    w_vc_next     = r_vc;
    if (w_h_wrap) begin
      w_vc_next   = w_v_wrap ? '0 : r_vc + 10'd1;
    end
    w_frame_start = (r_hc == '0) && (r_vc == '0);
  end

  // Coordinate source for the DrawX/DrawY registers
  always_comb begin
`ifdef VGA_TIMING_LOOKAHEAD_EN
    w_x_src = w_hc_next;
    w_y_src = w_vc_next;
`else
    w_x_src = r_hc;
    w_y_src = r_vc;
`endif
  end

  // Horizontal/vertical position counters
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hc <= '0;
      r_vc <= '0;
    end else begin
      r_hc <= w_hc_next;
      r_vc <= w_vc_next;
    end
  end

  // Registered outputs: one cycle after the counters hold a position
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_draw_x      <= '0;
      r_draw_y      <= '0;
      r_blank       <= 1'b0;
      r_hs          <= 1'b1;
      r_vs          <= 1'b1;
      r_frame_start <= 1'b0;
      r_frame_cnt   <= '0;
    end else begin
      r_draw_x      <= w_x_src;
      r_draw_y      <= w_y_src;
      r_blank       <= (r_hc < H_VIS_C) && (r_vc < V_VIS_C);
      r_hs          <= !in_span(r_hc, H_SYNC_BEG_C, H_SYNC_END_C);
      r_vs          <= !in_span(r_vc, V_SYNC_BEG_C, V_SYNC_END_C);
      r_frame_start <= w_frame_start;
      if (w_frame_start) begin
        r_frame_cnt <= r_frame_cnt + FRAME_CNT_W'(1);
      end
    end
  end

  assign DrawX       = r_draw_x;
  assign DrawY       = r_draw_y;
  assign blank       = r_blank;
  assign hs          = r_hs;
  assign vs          = r_vs;
  assign frame_start = r_frame_start;
  assign frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of vga_timing_gen (default and 2-bit frame counter).
// Long stretches of the frame are skipped by loading the position counters.
module tb_vga_timing_gen;

`ifdef VGA_TIMING_LOOKAHEAD_EN
  localparam bit LA = 1'b1;
`else
  localparam bit LA = 1'b0;
`endif

  logic       clk     = 1'b0;
  logic       reset_n = 1'b0;
  logic [9:0] x8, y8, x2, y2;
  logic       b8, h8, v8, f8, b2, h2, v2, f2;
  logic [7:0] c8;
  logic [1:0] c2;

  int n_checks = 0;
  int n_errors = 0;
  int hs_low;
  int vs_low;
  logic [9:0] j_hc = '0;
  logic [9:0] j_vc = '0;

  always #20 clk = ~clk;

  vga_timing_gen dut8 (
    .vga_clk(clk), .reset_n(reset_n), .DrawX(x8), .DrawY(y8), .blank(b8),
    .hs(h8), .vs(v8), .frame_start(f8), .frame_cnt(c8)
  );

  vga_timing_gen #(.FRAME_CNT_W(2)) dut2 (
    .vga_clk(clk), .reset_n(reset_n), .DrawX(x2), .DrawY(y2), .blank(b2),
    .hs(h2), .vs(v2), .frame_start(f2), .frame_cnt(c2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected outputs for presented pixel (px,py), both instances
  task automatic chk_pix(input int px, input int py);
    int    ex;
    int    ey;
    string t;
    ex = px;
    ey = py;
    if (LA) begin
      if (px == 799) begin
        ex = 0;
        ey = (py == 524) ? 0 : py + 1;
      end else begin
        ex = px + 1;
      end
    end
    t = $sformatf("(%0d,%0d)", px, py);
    chk({t, " DrawX"},        32'(x8), 32'(ex));
    chk({t, " DrawY"},        32'(y8), 32'(ey));
    chk({t, " blank"},        32'(b8), 32'(px < 640 && py < 480));
    chk({t, " hs"},           32'(h8), 32'(!(px >= 656 && px <= 751)));
    chk({t, " vs"},           32'(v8), 32'(!(py >= 490 && py <= 491)));
    chk({t, " frame_start"},  32'(f8), 32'(px == 0 && py == 0));
    chk({t, " w2 DrawX"},     32'(x2), 32'(ex));
    chk({t, " w2 DrawY"},     32'(y2), 32'(ey));
    chk({t, " w2 blank"},     32'(b2), 32'(px < 640 && py < 480));
    chk({t, " w2 hs"},        32'(h2), 32'(!(px >= 656 && px <= 751)));
    chk({t, " w2 vs"},        32'(v2), 32'(!(py >= 490 && py <= 491)));
    chk({t, " w2 frame_start"}, 32'(f2), 32'(px == 0 && py == 0));
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, " DrawX"},       32'(x8), 32'd0);
    chk({tag, " DrawY"},       32'(y8), 32'd0);
    chk({tag, " blank"},       32'(b8), 32'd0);
    chk({tag, " hs"},          32'(h8), 32'd1);
    chk({tag, " vs"},          32'(v8), 32'd1);
    chk({tag, " frame_start"}, 32'(f8), 32'd0);
    chk({tag, " frame_cnt"},   32'(c8), 32'd0);
    chk({tag, " w2 DrawX"},    32'(x2), 32'd0);
    chk({tag, " w2 DrawY"},    32'(y2), 32'd0);
    chk({tag, " w2 blank"},    32'(b2), 32'd0);
    chk({tag, " w2 hs"},       32'(h2), 32'd1);
    chk({tag, " w2 vs"},       32'(v2), 32'd1);
    chk({tag, " w2 frame_start"}, 32'(f2), 32'd0);
    chk({tag, " w2 frame_cnt"},   32'(c2), 32'd0);
  endtask

  // Load both position counters; called just after a falling edge
  task automatic jump(input logic [9:0] hc, input logic [9:0] vc);
    j_hc = hc;
    j_vc = vc;
    force dut8.r_hc = j_hc;
    force dut8.r_vc = j_vc;
    force dut2.r_hc = j_hc;
    force dut2.r_vc = j_vc;
    #1;
    release dut8.r_hc;
    release dut8.r_vc;
    release dut2.r_hc;
    release dut2.r_vc;
  endtask

  initial begin
    // Reset state
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_rst("reset");
    reset_n = 1'b1;

    // First line plus wrap into line 1
    hs_low = 0;
    for (int i = 0; i <= 800; i++) begin
      @(negedge clk);
      chk_pix(i % 800, i / 800);
      if (i == 0) begin
        chk("first frame_cnt", 32'(c8), 32'd1);
        chk("first w2 frame_cnt", 32'(c2), 32'd1);
      end
      if (i < 800 && !h8) hs_low++;
    end
    chk("line hs low cycles", 32'(hs_low), 32'd96);

    // Visible-area corner (639,479) -> (640,479)
    jump(10'd638, 10'd479);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk_pix(638 + k, 479);
    end

    // Vertical sync window: lines 489..492
    jump(10'd798, 10'd489);
    vs_low = 0;
    for (int i = 0; i < 1604; i++) begin
      @(negedge clk);
      chk_pix((798 + i) % 800, 489 + (798 + i) / 800);
      if (!v8) vs_low++;
    end
    chk("vs low cycles", 32'(vs_low), 32'd1600);

    // Frame wrap (799,524) -> (0,0)
    jump(10'd798, 10'd524);
    @(negedge clk); chk_pix(798, 524);
    @(negedge clk); chk_pix(799, 524);
    chk("pre-wrap frame_cnt", 32'(c8), 32'd1);
    @(negedge clk); chk_pix(0, 0);
    chk("wrap1 frame_cnt", 32'(c8), 32'd2);
    chk("wrap1 w2 frame_cnt", 32'(c2), 32'd2);
    @(negedge clk); chk_pix(1, 0);
    chk("post-wrap frame_cnt", 32'(c8), 32'd2);

    // Further frames: 2-bit counter goes 3,0,1
    for (int k = 0; k < 3; k++) begin
      jump(10'd799, 10'd524);
      @(negedge clk); chk_pix(799, 524);
      @(negedge clk); chk_pix(0, 0);
      chk($sformatf("wrap%0d frame_cnt", k + 2), 32'(c8), 32'(k + 3));
      chk($sformatf("wrap%0d w2 frame_cnt", k + 2), 32'(c2), 32'((k + 3) % 4));
    end

    // Asynchronous reset in mid-frame
    jump(10'd298, 10'd200);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk_pix(298 + k, 200);
    end
    #5 reset_n = 1'b0;
    #1 chk_rst("async reset");
    @(negedge clk);
    chk_rst("reset held");
    reset_n = 1'b1;
    @(negedge clk);
    chk_pix(0, 0);
    chk("rerelease frame_cnt", 32'(c8), 32'd1);
    chk("rerelease w2 frame_cnt", 32'(c2), 32'd1);
    @(negedge clk);
    chk_pix(1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
